// File: rtl/tt_ctrl_pkg.sv
// Shared definitions for the pad-level core-selection control path.
// Holds the selection FSM state encoding and the address field widths
// used by the receiver and anything that decodes its address.
package tt_ctrl_pkg;

  localparam int ADDR_W = 10;  // full selection address
  localparam int MUX_W  = 5;   // mux id field, sel_addr[9:5]
  localparam int BLK_W  = 5;   // block id field, sel_addr[4:0]

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SELECT = 2'd1,
    ST_ACTIVE = 2'd2
  } sel_state_e;

endpackage

// File: rtl/tt_ctrl_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous pad.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset; every stage loads RST_VAL
//   d   - asynchronous input
//   q   - synchronised output, STAGES clk edges behind d
module tt_ctrl_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/tt_ctrl_sel_rx.sv
// Mux-side receiver for the core-selection pad protocol.
// Synchronises ctrl_sel_rst_n / ctrl_sel_inc / ctrl_ena, counts increment
// edges into a 10-bit address, gates the enable through a RESET/SELECT/ACTIVE
// FSM and decodes the address into a local mux match and one-hot block select.
// Ports:
//   clk, rst        - block clock, asynchronous active-high reset
//   ctrl_sel_rst_n  - async pad, low clears the selection
//   ctrl_sel_inc    - async pad, rising edge increments the address
//   ctrl_ena        - async pad, high enables the selected design
//   sel_addr        - current address {mux id, block id}
//   sel_ena         - FSM is ACTIVE
//   local_ena       - sel_ena and mux id matches MUX_ID
//   blk_sel         - one-hot block select when local_ena, else 0
//   sel_err         - sticky, increment seen while ACTIVE
module tt_ctrl_sel_rx
  import tt_ctrl_pkg::*;
#(
  parameter int MUX_ID      = 0,
  parameter int N_BLK       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_sel_rst_n,
  input  logic              ctrl_sel_inc,
  input  logic              ctrl_ena,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              sel_ena,
  output logic              local_ena,
  output logic [N_BLK-1:0]  blk_sel,
  output logic              sel_err
);

  logic rst_n_s, inc_s, ena_s;

  // inc chain resets high so releasing rst with the pad low is not an edge
  tt_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rst_n (
    .clk(clk), .rst(rst), .d(ctrl_sel_rst_n), .q(rst_n_s));
  tt_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_inc (
    .clk(clk), .rst(rst), .d(ctrl_sel_inc), .q(inc_s));
  tt_ctrl_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ena (
    .clk(clk), .rst(rst), .d(ctrl_ena), .q(ena_s));

  sel_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              inc_prev_q;
  logic              local_q, local_d;
  logic [N_BLK-1:0]  blk_q, blk_d;
  logic              inc_evt;

  assign inc_evt = inc_s & ~inc_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      addr_q     <= '0;
      err_q      <= 1'b0;
      inc_prev_q <= 1'b1;
      local_q    <= 1'b0;
      blk_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      inc_prev_q <= inc_s;
      local_q    <= local_d;
      blk_q      <= blk_d;
    end
  end

  // Selection reset overrides everything, including a coincident increment.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (!rst_n_s) begin
      state_d = ST_RESET;
      addr_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RESET:  state_d = ST_SELECT;
        ST_SELECT: begin
          // increment lands even if ena rises in the same cycle
          if (inc_evt) addr_d  = addr_q + 1'b1;
          if (ena_s)   state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (inc_evt) err_d   = 1'b1;
          if (!ena_s)  state_d = ST_SELECT;
        end
        default:     state_d = ST_RESET;
      endcase
    end
  end

  // Decode from next-state values so the registered decode moves on the same
  // edge as sel_ena / sel_addr. Block ids >= N_BLK simply match no bit.
  always_comb begin
    local_d = (state_d == ST_ACTIVE) &&
              (addr_d[ADDR_W-1:BLK_W] == MUX_W'(MUX_ID));
    blk_d   = '0;
    for (int i = 0; i < N_BLK; i++)
      blk_d[i] = local_d && (addr_d[BLK_W-1:0] == BLK_W'(i));
  end

  assign sel_addr  = addr_q;
  assign sel_ena   = (state_q == ST_ACTIVE);
  assign local_ena = local_q;
  assign blk_sel   = blk_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_tt_ctrl_sel_rx.sv
// Bench for tt_ctrl_sel_rx: three instances with different MUX_ID/N_BLK share
// the same pads; a transaction-level model tracks the expected selection.
module tb_tt_ctrl_sel_rx;

  localparam int MUX_A = 12, NB_A = 32;
  localparam int MUX_B = 12, NB_B = 4;
  localparam int MUX_C = 3,  NB_C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl_sel_rst_n = 1'b0, ctrl_sel_inc = 1'b0, ctrl_ena = 1'b0;

  logic [9:0]  addr_a, addr_b, addr_c;
  logic        ena_a, ena_b, ena_c, loc_a, loc_b, loc_c, err_a, err_b, err_c;
  logic [NB_A-1:0] blk_a;
  logic [NB_B-1:0] blk_b;
  logic [NB_C-1:0] blk_c;

  always #5 clk = ~clk;

  tt_ctrl_sel_rx #(.MUX_ID(MUX_A), .N_BLK(NB_A), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena), .sel_addr(addr_a),
    .sel_ena(ena_a), .local_ena(loc_a), .blk_sel(blk_a), .sel_err(err_a));
  tt_ctrl_sel_rx #(.MUX_ID(MUX_B), .N_BLK(NB_B), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena), .sel_addr(addr_b),
    .sel_ena(ena_b), .local_ena(loc_b), .blk_sel(blk_b), .sel_err(err_b));
  tt_ctrl_sel_rx #(.MUX_ID(MUX_C), .N_BLK(NB_C), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst(rst), .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena), .sel_addr(addr_c),
    .sel_ena(ena_c), .local_ena(loc_c), .blk_sel(blk_c), .sel_err(err_c));

  int n_chk = 0;
  int n_err = 0;

  // model: 0 = reset, 1 = selecting, 2 = active
  int          st_m   = 0;
  int unsigned addr_m = 0;
  bit          err_m  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_blk(input bit loc, input int nb);
    logic [31:0] r;
    int          b;
    r = '0;
    b = int'(addr_m % 32);
    if (loc && b < nb) r[b] = 1'b1;
    return r;
  endfunction

  task automatic check_all(input string tag);
    bit la, lb, lc, act;
    @(negedge clk);
    act = (st_m == 2);
    la = act && (addr_m / 32 == MUX_A);
    lb = act && (addr_m / 32 == MUX_B);
    lc = act && (addr_m / 32 == MUX_C);
    chk({tag, ".addr_a"}, 64'(addr_a), 64'(addr_m));
    chk({tag, ".ena_a"},  64'(ena_a),  64'(act));
    chk({tag, ".loc_a"},  64'(loc_a),  64'(la));
    chk({tag, ".blk_a"},  64'(blk_a),  64'(exp_blk(la, NB_A)));
    chk({tag, ".err_a"},  64'(err_a),  64'(err_m));
    chk({tag, ".addr_b"}, 64'(addr_b), 64'(addr_m));
    chk({tag, ".loc_b"},  64'(loc_b),  64'(lb));
    chk({tag, ".blk_b"},  64'(blk_b),  64'(exp_blk(lb, NB_B)));
    chk({tag, ".ena_c"},  64'(ena_c),  64'(act));
    chk({tag, ".loc_c"},  64'(loc_c),  64'(lc));
    chk({tag, ".blk_c"},  64'(blk_c),  64'(exp_blk(lc, NB_C)));
    chk({tag, ".err_c"},  64'(err_c),  64'(err_m));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_sel_inc = 1'b1; tick(2);
      ctrl_sel_inc = 1'b0; tick(2);
      if (st_m == 1)      addr_m = (addr_m + 1) % 1024;
      else if (st_m == 2) err_m  = 1'b1;
    end
    tick(3);
  endtask

  task automatic set_ena(input bit v);
    ctrl_ena = v; tick(5);
    if (st_m != 0) st_m = v ? 2 : 1;
  endtask

  task automatic drop_sel;
    ctrl_sel_rst_n = 1'b0; tick(5);
    st_m = 0; addr_m = 0; err_m = 0;
  endtask

  task automatic raise_sel;
    ctrl_sel_rst_n = 1'b1; tick(5);
    st_m = ctrl_ena ? 2 : 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // pads wiggle while rst is held: nothing may move
    tick(1);
    for (int i = 0; i < 24; i++) begin
      ctrl_sel_rst_n = 1'($urandom); ctrl_sel_inc = 1'($urandom);
      ctrl_ena = 1'($urandom);
      tick(1);
      if (i % 6 == 5) check_all("hold_rst");
    end
    ctrl_sel_rst_n = 1'b0; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);
    check_all("rst_release");

    // 384 pulses then enable, with exact latency on sel_ena
    raise_sel();
    pulses(384);
    check_all("cnt384");
    ctrl_ena = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("ena_lat2", 64'(ena_a), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("ena_lat3", 64'(ena_a), 64'd1);
    chk("ena_lat3.blk", 64'(blk_a), 64'd1);
    st_m = 2;
    tick(2);
    check_all("active180");

    // increment while active is an error, address held
    pulses(1);
    check_all("active_inc");

    // dropping selection reset clears after 3 edges
    tick(1);
    ctrl_sel_rst_n = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("drop_lat2", 64'(addr_a), 64'h180);
    @(posedge clk); @(negedge clk);
    chk("drop_lat3.addr", 64'(addr_a), 64'h0);
    chk("drop_lat3.err",  64'(err_a),  64'h0);
    chk("drop_lat3.ena",  64'(ena_a),  64'h0);
    st_m = 0; addr_m = 0; err_m = 0;
    tick(2);
    check_all("dropped");
    set_ena(1'b0);

    // block id beyond N_BLK on the 4-block instances
    raise_sel();
    pulses(389);
    set_ena(1'b1);
    check_all("addr185");
    set_ena(1'b0);
    check_all("deact185");

    // wrap
    drop_sel(); raise_sel();
    pulses(1025);
    check_all("wrap");

    // selection reset coincident with an increment edge
    drop_sel(); raise_sel();
    pulses(5);
    check_all("at5");
    ctrl_sel_rst_n = 1'b0; ctrl_sel_inc = 1'b1;
    tick(5);
    st_m = 0; addr_m = 0; err_m = 0;
    check_all("rst_vs_inc");
    ctrl_sel_inc = 1'b0; tick(3);

    // async rst mid-count, checked before any further clock edge
    raise_sel();
    pulses(7);
    check_all("at7");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async.addr", 64'(addr_a), 64'h0);
    chk("async.ena",  64'(ena_a),  64'h0);
    chk("async.blk",  64'(blk_a),  64'h0);
    chk("async.err",  64'(err_a),  64'h0);
    st_m = 0; addr_m = 0; err_m = 0;
    ctrl_sel_rst_n = 1'b0; ctrl_ena = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);

    // randomized pad transactions
    raise_sel();
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: pulses(int'($urandom_range(1, 40)));
        3, 4:    set_ena(~ctrl_ena);
        default: if (ctrl_sel_rst_n) drop_sel(); else raise_sel();
      endcase
      check_all($sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tt_ctrl_sel_rx.md
# tt_ctrl_sel_rx

Mux-side receiver for the pad-level core-selection protocol (`ctrl_sel_rst_n`, `ctrl_sel_inc`, `ctrl_ena`). It synchronises the three asynchronous control pads and counts `ctrl_sel_inc` rising edges into a 10-bit address (mux id in [9:5], block id in [4:0]). It gates the enable through a small state machine and decodes the address into a local mux-match flag and a one-hot block select. It sits in the control path between the pad ring and the per-mux block-enable fabric.

## Interface
Parameters:
- `MUX_ID`, 0, this mux's 5-bit id compared against `sel_addr[9:5]`.
- `N_BLK`, 32, number of blocks on this mux, 1..32.
- `SYNC_STAGES`, 2, synchroniser depth, ≥2.

Ports:
- `clk`  in  1  block clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ctrl_sel_rst_n`  in  1  async pad; low clears the selection.
- `ctrl_sel_inc`  in  1  async pad; each rising edge increments the address.
- `ctrl_ena`  in  1  async pad; high enables the selected design.
- `sel_addr`  out  10  current selection address.
- `sel_ena`  out  1  selection active (state ACTIVE).
- `local_ena`  out  1  `sel_ena` and `sel_addr[9:5] == MUX_ID`.
- `blk_sel`  out  N_BLK  one-hot of `sel_addr[4:0]` when `local_ena`, else 0.
- `sel_err`  out  1  sticky: increment attempted while ACTIVE.

## Operation
- Each pad passes through a `SYNC_STAGES`-deep flop chain. The sync chains reset to 0 for `ctrl_sel_rst_n` and `ctrl_ena`, and to 1 for `ctrl_sel_inc`, so no spurious edge is seen at reset release.
- An increment event is a rising edge on synced `ctrl_sel_inc`: synced=1, previous synced=0.
- States:
  - RESET: synced `ctrl_sel_rst_n` = 0.
  - SELECT: counting.
  - ACTIVE: enabled.
- Transitions:
  - Any state → RESET when synced `ctrl_sel_rst_n` = 0. This has highest priority. On entry, `sel_addr` is cleared to 0 and `sel_err` is cleared.
  - RESET → SELECT when synced `ctrl_sel_rst_n` = 1.
  - SELECT → ACTIVE when synced `ctrl_ena` = 1.
  - ACTIVE → SELECT when synced `ctrl_ena` = 0. `sel_addr` is retained.
- In SELECT, an increment event does `sel_addr <= sel_addr + 1`, mod 1024 (0x3FF wraps to 0x000).
- In ACTIVE, an increment event is ignored and sets `sel_err`.
- In RESET, an increment event is ignored with no error.
- Simultaneous events:
  - Increment event and `ctrl_ena` rising in the same cycle while in SELECT: the increment applies, then the state becomes ACTIVE.
  - RESET condition together with anything: RESET wins.
- `blk_sel` is all-zero if `sel_addr[4:0] >= N_BLK`; `local_ena` is still asserted in that case.
- `rst` asserted at any time: all flops return to reset values immediately (asynchronous).

## Timing
- Reset values:
  - `sel_addr` = 0, `sel_ena` = 0, `local_ena` = 0, `blk_sel` = 0, `sel_err` = 0.
  - State = RESET.
- Latency, pad edge to registered outputs: `SYNC_STAGES` + 1 clk rising edges (3 at default). This applies to `sel_addr` update, `sel_ena` and state change.
- `local_ena` and `blk_sel` are registered and update on the same edge as `sel_ena` / `sel_addr`.
- Pad protocol requirement on the sender: `ctrl_sel_inc` stays high ≥2 clk and low ≥2 clk per pulse. Shorter pulses may be lost; they are not double-counted.
- `ctrl_ena` is raised only after the last increment has settled (≥3 clk).

## Structure
- Shared package/header `tt_ctrl_pkg`:
  - state encoding (RESET=2'd0, SELECT=2'd1, ACTIVE=2'd2);
  - `ADDR_W`=10, `MUX_W`=5, `BLK_W`=5.
- One sub-module `tt_ctrl_sync`: a parameterised-depth synchroniser with a reset-value parameter, instantiated three times.
- Counter, FSM and decode live in the top module.

## Test plan
- Hold `rst`=1 with pads toggling → all outputs 0, no count. Release `rst` with `ctrl_sel_rst_n`=0 → state RESET, `sel_addr`=0.
- `MUX_ID`=12: release `ctrl_sel_rst_n`, send 384 inc pulses (2 clk high / 2 clk low), then raise `ctrl_ena` → 3 clk later `sel_addr`=0x180, `sel_ena`=1, `local_ena`=1, `blk_sel`=1<<0.
- `MUX_ID`=12, `N_BLK`=4: send 389 pulses, then raise `ctrl_ena` → `sel_addr`=0x185, `local_ena`=1, `blk_sel`=0. Repeat with `MUX_ID`=3 → `local_ena`=0, `sel_ena`=1.
- Send 1025 pulses → `sel_addr`=0x001 (wrap at 0x3FF → 0x000).
- In ACTIVE with `sel_addr`=0x180, send 1 inc pulse → `sel_addr` stays 0x180 and `sel_err`=1. Then drop `ctrl_sel_rst_n` → 3 clk later `sel_addr`=0, `sel_err`=0, `sel_ena`=0.
- `ctrl_sel_rst_n` falls in the same clk as a `ctrl_sel_inc` rising edge at `sel_addr`=5 → `sel_addr`=0, no increment. Assert `rst` mid-count at `sel_addr`=7 → all outputs 0 without waiting for a clk edge.
